// File: rtl/adc2_pkg.sv
// Shared types and sizing helpers for the ADC2 frame-capture controller.
package adc2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  localparam int DATA_W_DEF = 16;
  localparam int WORD_W_DEF = 2 * DATA_W_DEF + 1;

  // Buffered word: {last, q2, q1}
  function automatic int word_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/adc2_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered output and synchronous flush.
module adc2_sync_fifo
  import adc2_pkg::*;
#(
  parameter int W     = WORD_W_DEF,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         wr_ready,
  input  logic         rd_ready,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         empty
);

  localparam int PW = ptr_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic          full, pop, wr_en;

  // One slot is left unused so full/empty come straight from the pointers;
  // the output register shows mem[rd_ptr] and is not an extra storage slot.
  assign full       = (wr_ptr_q + PW'(1)) == rd_ptr_q;
  assign empty      = wr_ptr_q == rd_ptr_q;
  assign pop        = dout_valid && rd_ready;
  assign wr_ready   = !full || pop;
  assign wr_en      = push && wr_ready && !flush;
  assign rd_ptr_nxt = rd_ptr_q + PW'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      rd_ptr_q   <= rd_ptr_nxt;
      // Compared against the pre-write pointer: a new word shows one edge after its push.
      dout_valid <= wr_ptr_q != rd_ptr_nxt;
      if (wr_ptr_q != rd_ptr_nxt) dout <= mem[rd_ptr_nxt];
    end
  end

endmodule

// File: rtl/adc2_capture_ctrl.sv
// ADC2 frame-capture controller: arm, trigger, decimated capture into a FIFO, valid/ready drain.
// state   | meaning
// IDLE    | waiting for arm with a non-zero frame length
// ARMED   | waiting for a software or rising level-crossing trigger
// CAPTURE | pushing decimated sample pairs until the last word is buffered
// DRAIN   | waiting for the FIFO and output register to empty, then pulse done
module adc2_capture_ctrl
  import adc2_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 12
) (
  input  logic                Adc2DCO_pi,
  input  logic                Adc2Rst_n,
  input  logic [DATA_W-1:0]   q1,
  input  logic [DATA_W-1:0]   q2,
  input  logic                arm,
  input  logic                abort,
  input  logic                trig_sw,
  input  logic                trig_lvl_en,
  input  logic [DATA_W-1:0]   trig_lvl,
  input  logic [LEN_W-1:0]    frame_len,
  input  logic [3:0]          decim,
  output logic [2*DATA_W-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  localparam int WORD_W = word_w(DATA_W);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, wrd_cnt_q;
  logic [3:0]          decim_q, dec_cnt_q;
  logic [DATA_W-1:0]   q1_prev_q;
  logic                prev_vld_q;
  logic                hold_vld_q;
  logic [2*DATA_W-1:0] hold_q;
  logic                ovf_q;

  logic                arm_ok, trig, slot, last_slot, push, drop, take_hold, lvl_hit;
  logic                fifo_wr_rdy, fifo_empty, fifo_dout_vld;
  logic [WORD_W-1:0]   fifo_din, fifo_dout;

  assign lvl_hit = trig_lvl_en && prev_vld_q && (q1_prev_q < trig_lvl) && (trig_lvl <= q1);

  always_ff @(posedge Adc2DCO_pi or negedge Adc2Rst_n) begin
    if (!Adc2Rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    arm_ok    = 1'b0;
    trig      = 1'b0;
    slot      = 1'b0;
    last_slot = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE:    arm_ok = arm && (frame_len != '0);
      ARMED:   trig   = trig_sw || lvl_hit;
      CAPTURE: slot   = !hold_vld_q && (dec_cnt_q == '0);
      DRAIN:   done   = fifo_empty && !fifo_dout_vld;
    endcase
    // The trigger cycle is push slot 0 of the frame.
    if (trig) begin
      slot      = 1'b1;
      last_slot = len_q == LEN_W'(1);
    end else if (slot) begin
      last_slot = wrd_cnt_q == (len_q - LEN_W'(1));
    end
    if (abort) begin
      arm_ok    = 1'b0;
      trig      = 1'b0;
      slot      = 1'b0;
      last_slot = 1'b0;
      done      = 1'b0;
    end
    push      = hold_vld_q ? !abort : slot;
    fifo_din  = hold_vld_q ? {1'b1, hold_q} : {last_slot, q2, q1};
    drop      = slot && !last_slot && !fifo_wr_rdy;
    take_hold = slot && last_slot && !fifo_wr_rdy;
    if (arm_ok) state_d = ARMED;
    if (trig)   state_d = CAPTURE;
    if (fifo_wr_rdy && ((slot && last_slot) || (hold_vld_q && !abort))) state_d = DRAIN;
    if (done || abort) state_d = IDLE;
  end

  always_ff @(posedge Adc2DCO_pi or negedge Adc2Rst_n) begin
    if (!Adc2Rst_n) begin
      len_q      <= '0;
      decim_q    <= '0;
      wrd_cnt_q  <= '0;
      dec_cnt_q  <= '0;
      q1_prev_q  <= '0;
      prev_vld_q <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      q1_prev_q  <= q1;
      prev_vld_q <= state_q == ARMED;
      if (arm_ok) begin
        len_q   <= frame_len;
        decim_q <= decim;
      end
      if (arm_ok)    ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
      // Slot 0 was taken on the trigger cycle, so both counters start one step in.
      if (trig) begin
        wrd_cnt_q <= LEN_W'(1);
        dec_cnt_q <= (decim_q == '0) ? 4'd0 : 4'd1;
      end else if (state_q == CAPTURE) begin
        dec_cnt_q <= (dec_cnt_q == decim_q) ? 4'd0 : dec_cnt_q + 4'd1;
        if (slot) wrd_cnt_q <= wrd_cnt_q + LEN_W'(1);
      end
      if (abort) begin
        hold_vld_q <= 1'b0;
      end else if (take_hold) begin
        hold_vld_q <= 1'b1;
        hold_q     <= {q2, q1};
      end else if (hold_vld_q && fifo_wr_rdy) begin
        hold_vld_q <= 1'b0;
      end
    end
  end

  adc2_sync_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (Adc2DCO_pi),
    .rst_n      (Adc2Rst_n),
    .flush      (abort),
    .push       (push),
    .din        (fifo_din),
    .wr_ready   (fifo_wr_rdy),
    .rd_ready   (m_ready),
    .dout       (fifo_dout),
    .dout_valid (fifo_dout_vld),
    .empty      (fifo_empty)
  );

  assign m_data  = fifo_dout[2*DATA_W-1:0];
  assign m_last  = fifo_dout_vld && fifo_dout[2*DATA_W];
  assign m_valid = fifo_dout_vld;
  assign busy    = state_q != IDLE;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_adc2_capture_ctrl.sv
// Directed bench for adc2_capture_ctrl: one task per scenario with inline expected values.
module tb_adc2_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] q1, q2, trig_lvl;
  logic        arm, abort, trig_sw, trig_lvl_en, m_ready;
  logic [11:0] frame_len;
  logic [3:0]  decim;
  logic [31:0] m_data;
  logic        m_valid, m_last, busy, done, ovf;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          xfer_cyc = 0;
  logic        ramp = 1'b0;
  logic [32:0] got_q [$];

  adc2_capture_ctrl dut (
    .Adc2DCO_pi  (clk),
    .Adc2Rst_n   (rst_n),
    .q1          (q1),
    .q2          (q2),
    .arm         (arm),
    .abort       (abort),
    .trig_sw     (trig_sw),
    .trig_lvl_en (trig_lvl_en),
    .trig_lvl    (trig_lvl),
    .frame_len   (frame_len),
    .decim       (decim),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      got_q.push_back({m_last, m_data});
      xfer_cyc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (ramp) begin
      q1 = q1 + 16'd1;
      q2 = q2 + 16'd1;
    end
  endtask

  // Arms on the next edge; returns just after that edge with arm low again.
  task automatic do_arm(input logic [11:0] len, input logic [3:0] dec);
    frame_len = len;
    decim     = dec;
    arm       = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    q1 = '0; q2 = '0; trig_lvl = '0;
    arm = 0; abort = 0; trig_sw = 0; trig_lvl_en = 0; m_ready = 0;
    frame_len = '0; decim = '0;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({m_valid, m_last, busy, done, ovf} !== 5'b0 || m_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: valid/last/busy/done/ovf=%b data=%h, required 00000 data=0",
               {m_valid, m_last, busy, done, ovf}, m_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int d0;
    logic [32:0] exp;
    got_q.delete();
    m_ready = 1'b1;
    do_arm(12'd4, 4'd0);
    trig_sw = 1'b1; q1 = 16'h0010; q2 = 16'h1000; ramp = 1'b1;
    d0 = done_cnt;
    tick();
    trig_sw = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_t1: m_valid=%b, required 0", m_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h1000_0010) begin
      errors++;
      $display("FAIL basic_latency_t2: m_valid=%b data=%h, required 1 data=10000010", m_valid, m_data);
    end
    for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
    ramp = 1'b0;
    checks++;
    if (done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d pulses, required 1", done_cnt - d0);
    end
    for (int i = 0; i < 4; i++) begin
      exp = {(i == 3), 16'h1000 + 16'(i), 16'h0010 + 16'(i)};
      checks++;
      if (i >= got_q.size()) begin
        errors++;
        $display("FAIL basic_word%0d: missing, required %h", i, exp);
      end else if (got_q[i] !== exp) begin
        errors++;
        $display("FAIL basic_word%0d: got %h, required %h", i, got_q[i], exp);
      end
    end
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL basic_word_count: got %0d, required 4", got_q.size());
    end
    checks++;
    if (done_cyc !== xfer_cyc + 1) begin
      errors++;
      $display("FAIL basic_done_timing: done at %0d, last transfer at %0d, required +1", done_cyc, xfer_cyc);
    end
    checks++;
    if (ovf !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end_flags: ovf=%b busy=%b, required 0 0", ovf, busy);
    end
  endtask

  task automatic test_decim();
    int d0;
    logic [32:0] exp;
    got_q.delete();
    m_ready = 1'b1;
    do_arm(12'd3, 4'd2);
    trig_sw = 1'b1; q1 = 16'h0000; q2 = 16'h2000; ramp = 1'b1;
    d0 = done_cnt;
    tick();
    trig_sw = 1'b0;
    for (int i = 0; i < 30 && done_cnt == d0; i++) tick();
    ramp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = {(i == 2), 16'h2000 + 16'(3 * i), 16'(3 * i)};
      checks++;
      if (i >= got_q.size()) begin
        errors++;
        $display("FAIL decim_word%0d: missing, required %h", i, exp);
      end else if (got_q[i] !== exp) begin
        errors++;
        $display("FAIL decim_word%0d: got %h, required %h", i, got_q[i], exp);
      end
    end
    checks++;
    if (got_q.size() != 3 || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL decim_frame: words=%0d done=%0d, required 3 words 1 done", got_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_level_trigger();
    int d0;
    got_q.delete();
    m_ready = 1'b1;
    trig_lvl_en = 1'b1;
    trig_lvl = 16'h8000;
    q1 = 16'h0000; q2 = 16'h3000;
    do_arm(12'd2, 4'd0);
    q1 = 16'h7FFE; ramp = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
    ramp = 1'b0;
    checks++;
    if (got_q.size() < 1 || got_q[0] !== {1'b0, 16'h3002, 16'h8000}) begin
      errors++;
      $display("FAIL level_word0: got %h (n=%0d), required 030028000", got_q.size() > 0 ? got_q[0] : 33'h0, got_q.size());
    end
    checks++;
    if (got_q.size() != 2 || got_q[1] !== {1'b1, 16'h3003, 16'h8001}) begin
      errors++;
      $display("FAIL level_word1: n=%0d, required 2 words ending 130038001", got_q.size());
    end
    // q1 sits far below the threshold before arm and jumps above it on the first ARMED cycle.
    got_q.delete();
    q1 = 16'h0000;
    do_arm(12'd2, 4'd0);
    q1 = 16'h9000; ramp = 1'b1;
    repeat (10) tick();
    ramp = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || m_valid !== 1'b0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL level_no_trigger: busy=%b valid=%b words=%0d, required 1 0 0", busy, m_valid, got_q.size());
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    trig_lvl_en = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL level_abort_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_overflow();
    int d0;
    logic [32:0] exp;
    got_q.delete();
    m_ready = 1'b0;
    do_arm(12'd40, 4'd0);
    trig_sw = 1'b1; q1 = 16'h0100; q2 = 16'h5100; ramp = 1'b1;
    d0 = done_cnt;
    tick();
    trig_sw = 1'b0;
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h5100_0100) begin
      errors++;
      $display("FAIL ovf_stall_early: valid=%b data=%h, required 1 51000100", m_valid, m_data);
    end
    repeat (30) tick();
    ramp = 1'b0;
    @(negedge clk);
    checks++;
    if (ovf !== 1'b1 || busy !== 1'b1 || m_data !== 32'h5100_0100 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL ovf_stall_late: ovf=%b busy=%b data=%h last=%b, required 1 1 51000100 0", ovf, busy, m_data, m_last);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? {1'b0, 16'h5100 + 16'(i), 16'h0100 + 16'(i)}
                     : {1'b1, 16'h5127, 16'h0127};
      checks++;
      if (i >= got_q.size()) begin
        errors++;
        $display("FAIL ovf_word%0d: missing, required %h", i, exp);
      end else if (got_q[i] !== exp) begin
        errors++;
        $display("FAIL ovf_word%0d: got %h, required %h", i, got_q[i], exp);
      end
    end
    checks++;
    if (got_q.size() != 16 || done_cnt !== d0 + 1 || done_cyc !== xfer_cyc + 1) begin
      errors++;
      $display("FAIL ovf_frame_end: words=%0d done=%0d done_cyc=%0d xfer_cyc=%0d, required 16 1 xfer+1",
               got_q.size(), done_cnt - d0, done_cyc, xfer_cyc);
    end
  endtask

  task automatic test_abort();
    int d0;
    got_q.delete();
    m_ready = 1'b0;
    do_arm(12'd20, 4'd0);
    trig_sw = 1'b1; q1 = 16'h0A00; q2 = 16'h0B00; ramp = 1'b1;
    d0 = done_cnt;
    tick();
    trig_sw = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || busy !== 1'b1 || m_data !== 32'h0B00_0A00) begin
      errors++;
      $display("FAIL abort_pre: valid=%b busy=%b data=%h, required 1 1 0b000a00", m_valid, busy, m_data);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ramp = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_post: valid=%b busy=%b, required 0 0", m_valid, busy);
    end
    repeat (5) tick();
    checks++;
    if (done_cnt !== d0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL abort_no_done: done=%0d words=%0d, required 0 0", done_cnt - d0, got_q.size());
    end
    m_ready = 1'b1;
    do_arm(12'd2, 4'd0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_rearm: busy=%b, required 1", busy);
    end
    trig_sw = 1'b1; q1 = 16'h0C00; q2 = 16'h0D00;
    tick();
    trig_sw = 1'b0;
    for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
    checks++;
    if (got_q.size() != 2 || got_q[got_q.size() - 1] !== {1'b1, 16'h0D00, 16'h0C00} || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL abort_next_frame: words=%0d done=%0d, required 2 words ending 10d000c00 and 1 done",
               got_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_arm_rules();
    int d0;
    got_q.delete();
    m_ready = 1'b1;
    do_arm(12'd0, 4'd0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL arm_len0: busy=%b, required 0", busy);
    end
    abort = 1'b1;
    do_arm(12'd3, 4'd0);
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL arm_with_abort: busy=%b, required 0", busy);
    end
    do_arm(12'd3, 4'd0);
    do_arm(12'd5, 4'd0);
    trig_sw = 1'b1; q1 = 16'h0E00; q2 = 16'h0F00; ramp = 1'b1;
    d0 = done_cnt;
    tick();
    trig_sw = 1'b0;
    for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
    ramp = 1'b0;
    checks++;
    if (got_q.size() != 3 || got_q[got_q.size() - 1] !== {1'b1, 16'h0F02, 16'h0E02}) begin
      errors++;
      $display("FAIL arm_while_armed: words=%0d, required 3 words ending 10f020e02", got_q.size());
    end
  endtask

  task automatic test_async_reset();
    int d0;
    m_ready = 1'b0;
    do_arm(12'd10, 4'd0);
    trig_sw = 1'b1;
    tick();
    trig_sw = 1'b0;
    repeat (4) tick();
    d0 = done_cnt;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || m_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b busy=%b data=%h, required 0 0 0", m_valid, busy, m_data);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_after: done=%0d busy=%b, required 0 0", done_cnt - d0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decim();
    test_level_trigger();
    test_overflow();
    test_abort();
    test_arm_rules();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
